// File: rtl/crt_csyncsep_if.sv
// Port bundle of the composite-sync separator.
// master: the sync source / timing consumer side; slave: the separator itself.
interface crt_csyncsep_if #(
    parameter int LW = 10
);
    logic          onemks;
    logic          csync;
    logic          hs;
    logic          vs;
    logic          vs_start;
    logic [LW-1:0] lines;
    logic          lines_vld;

    modport master (
        output onemks, csync,
        input  hs, vs, vs_start, lines, lines_vld
    );

    modport slave (
        input  onemks, csync,
        output hs, vs, vs_start, lines, lines_vld
    );
endinterface

// File: rtl/crt_csyncsep.sv
// Composite-sync separator: synchronises and deglitches the normalised
// composite sync, classifies each high pulse by its width in 1 us ticks and
// regenerates a line strobe, a vertical sync level, a frame-start strobe and
// an optional lines-per-frame count.
// Optional feature macro: CRT_CSYNCSEP_LINECNT_EN builds the line counter;
// without it `lines` and `lines_vld` are tied to 0.
module crt_csyncsep #(
    parameter int HMAX_US  = 8,
    parameter int VMIN_US  = 16,
    parameter int DEGLITCH = 3,
    parameter int LW       = 10
) (
    input  logic           clk,
    input  logic           reset,
    crt_csyncsep_if.slave  bus
);

    typedef enum logic {
        HSYNC = 1'b0,
        VSYNC = 1'b1
    } state_t;

    localparam logic [2:0] RUN_LAST = 3'(DEGLITCH - 1);
    localparam logic [5:0] VMIN_M1  = 6'(VMIN_US - 1);
    localparam logic [5:0] HMAX_W   = 6'(HMAX_US);
    localparam logic [5:0] WCNT_MAX = 6'd63;

    logic       sync1_q;
    logic       sync2_q;
    logic       cs_f_q;
    logic       cs_f_d;
    logic       cs_f_dly_q;
    logic [2:0] run_q;
    logic [2:0] run_d;
    logic       rise;
    logic       fall;
    logic [5:0] wcnt_q;
    logic [5:0] wcnt_d;
    logic       wcnt_inc;
    logic       vmin_hit;
    logic       hmax_ok;
    state_t     state_q;
    logic       hs_q;
    logic       vs_q;
    logic       vs_start_q;

    // Two-flop synchroniser for the asynchronous composite sync.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= bus.csync;
            sync2_q <= sync1_q;
        end
    end

    // Deglitch: accept a new level once it has differed for DEGLITCH cycles.
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        cs_f_d = cs_f_q;
        run_d  = '0;
        if (sync2_q != cs_f_q) begin
            if (run_q == RUN_LAST) begin
                cs_f_d = sync2_q;
            end else begin
                run_d = run_q + 3'd1;
            end
        end
    end

    // Filtered level, its run counter and the delayed copy used for edge flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            cs_f_q     <= 1'b0;
            run_q      <= '0;
            cs_f_dly_q <= 1'b0;
        end else begin
            cs_f_q     <= cs_f_d;
            run_q      <= run_d;
            cs_f_dly_q <= cs_f_q;
        end
    end

    assign rise = cs_f_q & ~cs_f_dly_q;
    assign fall = ~cs_f_q & cs_f_dly_q;

    // Pulse width in us ticks; the clear on rise wins over a coincident tick.
    assign wcnt_inc = cs_f_q & bus.onemks & ~rise & (wcnt_q != WCNT_MAX);
    assign vmin_hit = wcnt_inc & (wcnt_q == VMIN_M1);
    assign hmax_ok  = (wcnt_q <= HMAX_W);

    // Next width count: clear, count up or hold.
    always_comb begin
        wcnt_d = wcnt_q;
        if (rise) begin
            wcnt_d = '0;
        end else if (wcnt_inc) begin
            wcnt_d = wcnt_q + 6'd1;
        end
    end

    // Width counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            wcnt_q <= '0;
        end else begin
            wcnt_q <= wcnt_d;
        end
    end

    // Horizontal/vertical classification FSM with registered strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= HSYNC;
            hs_q       <= 1'b0;
            vs_q       <= 1'b0;
            vs_start_q <= 1'b0;
        end else begin
            hs_q       <= rise;
            vs_start_q <= 1'b0;
            case (state_q)
                HSYNC: begin
                    if (vmin_hit) begin
                        state_q    <= VSYNC;
                        vs_q       <= 1'b1;
                        vs_start_q <= 1'b1;
                    end
                end
                VSYNC: begin
                    // Serrations are long pulses, so only a normal-width
                    // pulse ends the vertical interval.
                    if (fall && hmax_ok) begin
                        state_q <= HSYNC;
                        vs_q    <= 1'b0;
                    end
                end
                default: begin
                    state_q <= HSYNC;
                    vs_q    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.hs       = hs_q;
    assign bus.vs       = vs_q;
    assign bus.vs_start = vs_start_q;

`ifdef CRT_CSYNCSEP_LINECNT_EN
    logic [LW-1:0] lcnt_q;
    logic [LW-1:0] lines_q;
    logic          lines_vld_q;

    // Count line strobes; hand the count over at each frame start.
    always_ff @(posedge clk) begin
        if (reset) begin
            lcnt_q      <= '0;
            lines_q     <= '0;
            lines_vld_q <= 1'b0;
        end else if (vs_start_q) begin
            lines_q     <= lcnt_q;
            lcnt_q      <= '0;
            lines_vld_q <= 1'b1;
        end else if (hs_q && (lcnt_q != {LW{1'b1}})) begin
            lcnt_q <= lcnt_q + 1'b1;
        end
    end

    assign bus.lines     = lines_q;
    assign bus.lines_vld = lines_vld_q;
`else
    assign bus.lines     = {LW{1'b0}};
    assign bus.lines_vld = 1'b0;
`endif

endmodule
